rr_req_frontend: RTL and testbench
==================================

// Module: rr_req_frontend
// PURPOSE
// Requester-side front end of the 8-way round-robin arbiter.
// - Buffers words from 8 client channels in per-channel FIFOs and drives the arbiter's req lines.
// - Consumes the arbiter's registered one-hot grant and forwards the granted channel's head word to one shared sink.
// - Tolerates stale requests caused by the arbiter's 2-cycle req->grant pipeline.
// PARAMETERS
// NCH     8   number of client channels; fixed to 8, matching the arbiter width
// DATA_W  16  payload width per channel
// DEPTH   4   entries per channel FIFO; power of 2, >= 2
// PORTS
// clk        in   1            clock, rising edge
// rst_n      in   1            reset, asynchronous, active-low
// in_valid   in   NCH          per-channel push request
// in_data    in   NCH*DATA_W   channel i payload at [i*DATA_W +: DATA_W]
// in_ready   out  NCH          channel i FIFO can accept a word
// req        out  NCH          request to arbiter; req[i] drives arbiter req(i+1)
// grant      in   NCH          one-hot grant from arbiter grant_out; 0 = none
// out_valid  out  1            shared sink word valid
// out_data   out  DATA_W       forwarded payload
// out_ch     out  3            source channel index of out_data
// out_ready  in   1            sink accepts word
// grant_err  out  1            sticky: multi-hot grant seen
// waste_cnt  out  8            saturating count of unused grants
// BEHAVIOUR
// Reset: all FIFO counts/pointers 0; out_valid=0, out_data=0, out_ch=0, grant_err=0, waste_cnt=0.
//   Reset mid-operation discards all buffered and in-flight data.
// FIFO i:
// - in_ready[i] = (count[i] != DEPTH), from registered count only.
// - push = in_valid[i] & in_ready[i]; push and pop in the same cycle leave count unchanged.
// - Pointers wrap modulo DEPTH.
// req[i] = (count[i] != 0), combinational from registers.
//   Stale requests are expected: grant can arrive for a now-empty channel.
// Grant decode each cycle:
// - g_one = grant has exactly one bit set; gi = its index.
// - g_multi = two or more bits set.
// accept = g_one & count[gi]!=0 & (!out_valid | out_ready).
// On accept (edge closing the grant cycle):
// - pop FIFO gi;
// - out_data <= head[gi], out_ch <= gi, out_valid <= 1.
// - Latency: grant cycle -> out_valid 1 cycle later.
// Else, if out_valid & out_ready: out_valid <= 0.
// Unused grant:
// - g_one & !accept: no pop, data stays buffered, waste_cnt++ (saturates at 255).
// - Sources: empty channel, or sink stalled.
// - The arbiter re-grants later via round-robin; no handshake back to it.
// g_multi: no pop, no output change, grant_err <= 1 (sticky until reset); waste_cnt unchanged.
// grant == 0: idle, no counters change.
// out_data/out_ch hold while out_valid & !out_ready. One word transferred per accepted grant.
// TESTING
// 1. Reset asserted mid-traffic -> all outputs 0, req=0, in_ready=8'hFF next cycle.
// 2. Push A1,A2,A3 on ch2, grant=8'h04 for 3 cycles, out_ready=1
//    -> out_valid 3 cycles, out_data A1,A2,A3, out_ch=2, req[2] falls.
// 3. ch5 empty, grant=8'h20 one cycle -> no output, waste_cnt=1.
// 4. ch0 holds B1, out_valid=1 with out_ready=0, grant=8'h01
//    -> B1 retained, req[0]=1, waste_cnt+1; next grant with out_ready=1 forwards B1.
// 5. grant=8'h05 -> grant_err=1, no pops; persists until rst_n low.
// 6. Push DEPTH words on ch7 -> in_ready[7]=0;
//    at count=1 with simultaneous push+grant -> count stays 1, output correct.

Source files
------------

// File: rtl/rr_req_frontend.sv
// Requester front end for the 8-way round-robin arbiter: per-channel FIFOs drive req, registered grant pops one head word to a shared sink.
// Latency: grant cycle -> out_valid next cycle; unusable grants (empty channel / stalled sink) are counted, never retried here.
module rr_req_frontend #(
    parameter int NCH    = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH-1:0]        in_valid,
    input  logic [NCH*DATA_W-1:0] in_data,
    output logic [NCH-1:0]        in_ready,
    output logic [NCH-1:0]        req,
    input  logic [NCH-1:0]        grant,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [2:0]            out_ch,
    input  logic                  out_ready,
    output logic                  grant_err,
    output logic [7:0]            waste_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem   [NCH][DEPTH];
    logic [CW-1:0]     count [NCH];
    logic [PW-1:0]     wptr  [NCH];
    logic [PW-1:0]     rptr  [NCH];

    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;
    logic           g_one;
    logic           g_multi;
    logic [2:0]     g_idx;
    logic           accept;
    logic [DATA_W-1:0] head;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            in_ready[i] = (count[i] != CW'(DEPTH));
            req[i]      = (count[i] != '0);
        end
    end

    assign push = in_valid & in_ready;

    // Single-bit grant test without a popcount: clearing the lowest set bit leaves zero.
    assign g_one   = (grant != '0) && ((grant & (grant - NCH'(1))) == '0);
    assign g_multi = (grant != '0) && !g_one;

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) g_idx = i[2:0];
        end
    end

    assign head   = mem[g_idx][rptr[g_idx]];
    assign accept = g_one && (count[g_idx] != '0) && (!out_valid || out_ready);

    always_comb begin
        pop = '0;
        if (accept) pop[g_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (push[i]) mem[i][wptr[i]] <= in_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                count[i] <= '0;
                wptr[i]  <= '0;
                rptr[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (push[i]) wptr[i] <= wptr[i] + PW'(1);
                if (pop[i])  rptr[i] <= rptr[i] + PW'(1);
                if (push[i] && !pop[i])      count[i] <= count[i] + CW'(1);
                else if (pop[i] && !push[i]) count[i] <= count[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            grant_err <= 1'b0;
            waste_cnt <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= head;
                out_ch    <= g_idx;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (g_multi) grant_err <= 1'b1;
            if (g_one && !accept && waste_cnt != 8'hFF) waste_cnt <= waste_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_rr_req_frontend.sv
// Randomized and directed stimulus for rr_req_frontend, checked every cycle against a queue-based model.
module tb_rr_req_frontend;
    localparam int NCH = 8, DW = 16, DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    in_valid;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_ready;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    grant;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [2:0]        out_ch;
    logic              out_ready;
    logic              grant_err;
    logic [7:0]        waste_cnt;

    rr_req_frontend #(.NCH(NCH), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .req(req), .grant(grant), .out_valid(out_valid),
        .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready),
        .grant_err(grant_err), .waste_cnt(waste_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: plain queues per channel plus the sink register view.
    logic [DW-1:0] mq [NCH][$];
    logic          m_ov;
    logic [DW-1:0] m_od;
    logic [2:0]    m_ch;
    logic          m_err;
    int            m_waste;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) mq[i].delete();
        m_ov = 0; m_od = '0; m_ch = '0; m_err = 0; m_waste = 0;
    endtask

    task automatic model_step();
        int ones, gi;
        bit acc;
        bit do_push [NCH];
        ones = $countones(grant);
        gi = 0;
        for (int i = 0; i < NCH; i++) if (grant[i]) gi = i;
        acc = (ones == 1) && (mq[gi].size() != 0) && (!m_ov || out_ready);
        for (int i = 0; i < NCH; i++) do_push[i] = in_valid[i] && (mq[i].size() != DEPTH);
        if (acc) begin
            m_od = mq[gi].pop_front();
            m_ch = 3'(gi);
            m_ov = 1;
        end else if (m_ov && out_ready) begin
            m_ov = 0;
        end
        for (int i = 0; i < NCH; i++) if (do_push[i]) mq[i].push_back(in_data[i*DW +: DW]);
        if (ones == 1 && !acc && m_waste < 255) m_waste++;
        if (ones > 1) m_err = 1;
    endtask

    task automatic compare_all();
        logic [NCH-1:0] e_rdy, e_req;
        for (int i = 0; i < NCH; i++) begin
            e_rdy[i] = (mq[i].size() != DEPTH);
            e_req[i] = (mq[i].size() != 0);
        end
        check("in_ready", 32'(in_ready), 32'(e_rdy));
        check("req", 32'(req), 32'(e_req));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_data", 32'(out_data), 32'(m_od));
        check("out_ch", 32'(out_ch), 32'(m_ch));
        check("grant_err", 32'(grant_err), 32'(m_err));
        check("waste_cnt", 32'(waste_cnt), 32'(m_waste));
    endtask

    // Called at a negedge: apply inputs, advance the model, let the DUT clock, compare at the next negedge.
    task automatic cyc(input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d,
                       input logic [NCH-1:0] g, input logic ordy);
        in_valid = v; in_data = d; grant = g; out_ready = ordy;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [NCH*DW-1:0] put(input int ch, input logic [DW-1:0] w);
        logic [NCH*DW-1:0] d;
        d = '0;
        d[ch*DW +: DW] = w;
        return d;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        compare_all();
        check("rst_in_ready", 32'(in_ready), 32'hFF);
        @(negedge clk);
        in_valid = '0; grant = '0; out_ready = 1'b0;
        rst_n = 1'b1;
        compare_all();
    endtask

    task automatic rand_cycles(input int n, input bit allow_multi);
        logic [NCH-1:0]    v, g;
        logic [NCH*DW-1:0] d;
        int r;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < NCH; i++) begin
                v[i] = ($urandom_range(0, 99) < 30);
                d[i*DW +: DW] = DW'($urandom);
            end
            r = $urandom_range(0, 99);
            if (r < 55)                     g = NCH'(1) << $urandom_range(0, NCH - 1);
            else if (allow_multi && r < 60) g = NCH'($urandom) | NCH'(8'h81);
            else                            g = '0;
            cyc(v, d, g, $urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        logic [DW-1:0] a [3];
        rst_n = 1'b0; in_valid = '0; in_data = '0; grant = '0; out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // ch2 FIFO order and req drop after draining
        a[0] = 16'hA001; a[1] = 16'hA002; a[2] = 16'hA003;
        for (int k = 0; k < 3; k++) cyc(8'h04, put(2, a[k]), 8'h00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(8'h00, '0, 8'h04, 1'b1);
            check("t2_data", 32'(out_data), 32'(a[k]));
            check("t2_ch", 32'(out_ch), 32'd2);
        end
        check("t2_req2", 32'(req[2]), 32'd0);
        cyc(8'h00, '0, 8'h00, 1'b1);

        // grant to an empty channel is wasted
        cyc(8'h00, '0, 8'h20, 1'b1);
        check("t3_waste", 32'(waste_cnt), 32'd1);
        check("t3_ov", 32'(out_valid), 32'd0);

        // stalled sink: grant on ch0 wasted, B1 stays, later forwarded
        cyc(8'h03, put(0, 16'hB001) | put(1, 16'hC001), 8'h00, 1'b0);
        cyc(8'h00, '0, 8'h02, 1'b0);
        cyc(8'h00, '0, 8'h01, 1'b0);
        check("t4_req0", 32'(req[0]), 32'd1);
        check("t4_waste", 32'(waste_cnt), 32'd2);
        cyc(8'h00, '0, 8'h01, 1'b1);
        check("t4_data", 32'(out_data), 32'hB001);
        check("t4_ch", 32'(out_ch), 32'd0);
        cyc(8'h00, '0, 8'h00, 1'b1);

        // ch7 fill to full, drain to one, then push+pop together
        for (int k = 0; k < DEPTH; k++) cyc(8'h80, put(7, 16'hD000 + 16'(k)), 8'h00, 1'b1);
        check("t6_full", 32'(in_ready[7]), 32'd0);
        for (int k = 0; k < DEPTH - 1; k++) cyc(8'h00, '0, 8'h80, 1'b1);
        cyc(8'h80, put(7, 16'hD00F), 8'h80, 1'b1);
        check("t6_data", 32'(out_data), 32'hD003);
        check("t6_req7", 32'(req[7]), 32'd1);
        cyc(8'h00, '0, 8'h80, 1'b1);
        check("t6_tail", 32'(out_data), 32'hD00F);
        check("t6_empty", 32'(req[7]), 32'd0);

        // multi-hot grant: sticky error, no pop
        cyc(8'h01, put(0, 16'hE001), 8'h00, 1'b1);
        cyc(8'h00, '0, 8'h05, 1'b1);
        check("t5_err", 32'(grant_err), 32'd1);
        check("t5_req0", 32'(req[0]), 32'd1);
        cyc(8'h00, '0, 8'h00, 1'b1);
        check("t5_sticky", 32'(grant_err), 32'd1);

        // reset mid-traffic, then long random runs
        rand_cycles(200, 1'b0);
        in_valid = 8'hFF; grant = 8'h10;
        apply_reset();
        rand_cycles(2500, 1'b0);
        rand_cycles(400, 1'b1);
        apply_reset();
        rand_cycles(300, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
